// File: rtl/bs_adder.sv
// Bit-serial adder: LSB-first operands on x/y, registered sum on z.
// Optional word length clears the carry at every word boundary.
module bs_adder #(
    parameter int unsigned WORD_LEN = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic y,
    output logic z
);

    logic c;
    logic c_next;
    logic wrap;

    assign c_next = (x & y) | (x & c) | (y & c);

    generate
        if (WORD_LEN > 0) begin : g_cnt
            localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
            localparam logic [CW-1:0] LAST = CW'(WORD_LEN - 1);

            logic [CW-1:0] cnt;

            assign wrap = (cnt == LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                end else if (wrap) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_free
            assign wrap = 1'b0;
        end
    endgenerate

    // Final bit of a word drops its carry-out: sum is modulo 2^WORD_LEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
            z <= 1'b0;
        end else begin
            z <= x ^ y ^ c;
            c <= wrap ? 1'b0 : c_next;
        end
    end

endmodule

// File: tb/tb_bs_adder.sv
// Directed bench for bs_adder: free-running (WORD_LEN=0) and
// 4-bit word (WORD_LEN=4) instances share the same stimulus.
module tb_bs_adder;

    logic clk;
    logic rst;
    logic x;
    logic y;
    logic z0;
    logic z4;

    int checks = 0;
    int errors = 0;

    bs_adder #(.WORD_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z0)
    );

    bs_adder #(.WORD_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic xi, input logic yi, input logic ri);
        x   = xi;
        y   = yi;
        rst = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (z0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_z0 got %b want 0", z0);
        end
        checks++;
        if (z4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_z4 got %b want 0", z4);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (z0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry_z0 got %b want 0", z0);
        end
        checks++;
        if (z4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry_z4 got %b want 0", z4);
        end
    endtask

    // 5 + 3 = 8, LSB first
    task automatic test_basic;
        logic [3:0] xv;
        logic [3:0] yv;
        logic [3:0] ev;
        xv = 4'b0101;
        yv = 4'b0011;
        ev = 4'b1000;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(xv[i], yv[i], 1'b0);
            checks++;
            if (z0 !== ev[i]) begin
                errors++;
                $display("FAIL basic bit%0d got %b want %b", i, z0, ev[i]);
            end
        end
    endtask

    task automatic test_carry;
        logic [6:0] ev;
        ev = 7'b0111110;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i < 5) step(1'b1, 1'b1, 1'b0);
            else step(1'b0, 1'b0, 1'b0);
            checks++;
            if (z0 !== ev[i]) begin
                errors++;
                $display("FAIL carry bit%0d got %b want %b", i, z0, ev[i]);
            end
        end
    endtask

    // 15+15 then 0+0: word engine drops carry, free engine keeps it
    task automatic test_wrap;
        logic [7:0] e4;
        logic [7:0] e0;
        e4 = 8'b0000_1110;
        e0 = 8'b0001_1110;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(1'b1, 1'b1, 1'b0);
            else step(1'b0, 1'b0, 1'b0);
            checks++;
            if (z4 !== e4[i]) begin
                errors++;
                $display("FAIL wrap4 bit%0d got %b want %b", i, z4, e4[i]);
            end
            checks++;
            if (z0 !== e0[i]) begin
                errors++;
                $display("FAIL wrap0 bit%0d got %b want %b", i, z0, e0[i]);
            end
        end
    endtask

    // Words 3+1, 15+1, 1+0 with no bubbles
    task automatic test_back_to_back;
        logic [11:0] xv;
        logic [11:0] yv;
        logic [11:0] ev;
        xv = 12'b0001_1111_0011;
        yv = 12'b0000_0001_0001;
        ev = 12'b0001_0000_0100;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(xv[i], yv[i], 1'b0);
            checks++;
            if (z4 !== ev[i]) begin
                errors++;
                $display("FAIL b2b bit%0d got %b want %b", i, z4, ev[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] e4;
        logic [3:0] e0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (z0 !== 1'b0 || z4 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_z got %b%b want 00", z0, z4);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (z0 !== 1'b1 || z4 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_stale got %b%b want 11", z0, z4);
        end
        // bits 1..3 of the new word, then bit 0 of the next
        e4 = 4'b0110;
        e0 = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1'b1, 1'b1, 1'b0);
            else step(1'b0, 1'b0, 1'b0);
            checks++;
            if (z4 !== e4[i]) begin
                errors++;
                $display("FAIL midrst_cnt4 bit%0d got %b want %b",
                         i, z4, e4[i]);
            end
            checks++;
            if (z0 !== e0[i]) begin
                errors++;
                $display("FAIL midrst_cnt0 bit%0d got %b want %b",
                         i, z0, e0[i]);
            end
        end
    endtask

    // Fixed mixed pattern against a small carry model
    task automatic test_pattern;
        logic [15:0] xv;
        logic [15:0] yv;
        logic        m0;
        logic        m4;
        logic        e0;
        logic        e4;
        xv = 16'hA5C3;
        yv = 16'h3C96;
        m0 = 1'b0;
        m4 = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            e0 = xv[i] ^ yv[i] ^ m0;
            e4 = xv[i] ^ yv[i] ^ m4;
            m0 = (xv[i] & yv[i]) | (xv[i] & m0) | (yv[i] & m0);
            m4 = (i % 4 == 3) ? 1'b0 :
                 ((xv[i] & yv[i]) | (xv[i] & m4) | (yv[i] & m4));
            step(xv[i], yv[i], 1'b0);
            checks++;
            if (z0 !== e0) begin
                errors++;
                $display("FAIL pat0 bit%0d got %b want %b", i, z0, e0);
            end
            checks++;
            if (z4 !== e4) begin
                errors++;
                $display("FAIL pat4 bit%0d got %b want %b", i, z4, e4);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        x   = 1'b0;
        y   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        test_pattern();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
